// File: rtl/picosoc_timer_pkg.sv
// Shared definitions for the iomem timer: register word offsets, bit positions,
// bus FSM encoding and a byte-lane merge helper.
package picosoc_timer_pkg;

    // Word offsets, i.e. iomem_addr[7:2]
    localparam logic [5:0] OFF_CTRL     = 6'h00;
    localparam logic [5:0] OFF_PRESCALE = 6'h01;
    localparam logic [5:0] OFF_RELOAD   = 6'h02;
    localparam logic [5:0] OFF_COUNT    = 6'h03;
    localparam logic [5:0] OFF_STATUS   = 6'h04;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;
    localparam int STATUS_EXPIRED   = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/picosoc_timer_prescaler.sv
// Prescaler: pcnt runs 0..prescale while enabled and emits one tick per wrap.
module picosoc_timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pcnt;

    assign tick = en && (pcnt == prescale);

    always_ff @(posedge clk) begin
        if (reset || !en || clr || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/picosoc_timer.sv
// Memory-mapped down-counting timer on the iomem bus with one wait state and a
// level interrupt on expiry.
//
// state   | meaning
// ST_IDLE | waiting for a selected request; commits writes / captures read data
// ST_ACK  | iomem_ready high for one cycle, then back to idle unconditionally
module picosoc_timer
    import picosoc_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);

    bus_state_t state, state_next;

    logic                  sel, accept, wr_en;
    logic [5:0]            off;
    logic [1:0]            unused_addr;
    logic                  ctrl_en, ctrl_auto, ctrl_irq_en, expired;
    logic [2:0]            ctrl_wr;
    logic [PRESCALE_W-1:0] prescale, prescale_wr;
    logic [31:0]           reload, count, rd_val, rdata_q;
    logic                  wr_ctrl, wr_prescale, wr_reload, wr_count, wr_status;
    logic                  en_rise, w1c, tick;

    assign unused_addr = iomem_addr[1:0];
    assign sel         = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
    assign accept      = (state == ST_IDLE) && sel;
    assign wr_en       = accept && (iomem_wstrb != 4'b0000);
    assign off         = iomem_addr[7:2];

    assign wr_ctrl     = wr_en && (off == OFF_CTRL);
    assign wr_prescale = wr_en && (off == OFF_PRESCALE);
    assign wr_reload   = wr_en && (off == OFF_RELOAD);
    assign wr_count    = wr_en && (off == OFF_COUNT);
    assign wr_status   = wr_en && (off == OFF_STATUS);

    // All CTRL bits live in byte lane 0
    assign ctrl_wr = iomem_wstrb[0] ? iomem_wdata[2:0] : {ctrl_irq_en, ctrl_auto, ctrl_en};
    assign en_rise = wr_ctrl && ctrl_wr[CTRL_EN] && !ctrl_en;
    assign w1c     = wr_status && iomem_wstrb[0] && iomem_wdata[STATUS_EXPIRED];
    assign irq     = expired && ctrl_irq_en;

    always_comb begin
        prescale_wr = prescale;
        for (int i = 0; i < PRESCALE_W; i++) begin
            if (iomem_wstrb[i/8]) prescale_wr[i] = iomem_wdata[i];
        end
    end

    picosoc_timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (ctrl_en),
        .clr      (wr_prescale || wr_count || en_rise),
        .prescale (prescale),
        .tick     (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (sel) state_next = ST_ACK;
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        iomem_ready = (state == ST_ACK);
        iomem_rdata = iomem_ready ? rdata_q : 32'h0;
    end

    always_comb begin
        rd_val = 32'h0;
        case (off)
            OFF_CTRL:     rd_val[2:0] = {ctrl_irq_en, ctrl_auto, ctrl_en};
            OFF_PRESCALE: rd_val[PRESCALE_W-1:0] = prescale;
            OFF_RELOAD:   rd_val = reload;
            OFF_COUNT:    rd_val = count;
            OFF_STATUS:   rd_val[STATUS_EXPIRED] = expired;
            default:      rd_val = 32'h0;
        endcase
    end

    // Statement order encodes priority: expiry beats W1C, bus writes beat the tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en     <= 1'b0;
            ctrl_auto   <= 1'b0;
            ctrl_irq_en <= 1'b0;
            expired     <= 1'b0;
            prescale    <= '0;
            reload      <= 32'h0;
            count       <= 32'h0;
            rdata_q     <= 32'h0;
        end else begin
            if (w1c) expired <= 1'b0;
            if (tick) begin
                if (count != 32'h0) begin
                    count <= count - 32'd1;
                end else begin
                    expired <= 1'b1;
                    if (ctrl_auto) count   <= reload;
                    else           ctrl_en <= 1'b0;
                end
            end
            if (wr_ctrl) begin
                ctrl_en     <= ctrl_wr[CTRL_EN];
                ctrl_auto   <= ctrl_wr[CTRL_AUTO_RELOAD];
                ctrl_irq_en <= ctrl_wr[CTRL_IRQ_EN];
            end
            if (wr_prescale) prescale <= prescale_wr;
            if (wr_reload)   reload   <= merge_bytes(reload, iomem_wdata, iomem_wstrb);
            if (wr_count)    count    <= merge_bytes(count, iomem_wdata, iomem_wstrb);
            if (accept)      rdata_q  <= rd_val;
        end
    end

endmodule

// File: doc/picosoc_timer.md
# picosoc_timer

Memory-mapped down-counting timer that sits on the SoC's external `iomem` bus as a responder, the opposite end of the CPU-side `iomem_valid`/`iomem_ready` initiator port. It decodes a 256-byte window and answers reads and writes with one wait state. It generates a level interrupt on expiry, intended for the SoC's `irq_5` input.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0300_0000, window base; only `[31:8]` compared.
- `PRESCALE_W`, 16, prescaler width (1..32).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `iomem_valid`  in  1  transaction request.
- `iomem_ready`  out  1  one-cycle acknowledge.
- `iomem_wstrb`  in  4  byte write strobes; 0 = read.
- `iomem_addr`  in  32  byte address.
- `iomem_wdata`  in  32  write data.
- `iomem_rdata`  out  32  read data, valid only while `iomem_ready`=1, else 0.
- `irq`  out  1  `STATUS.EXPIRED & CTRL.IRQ_EN`.

## Operation
- Select: `sel = iomem_valid && iomem_addr[31:8] == BASE_ADDR[31:8]`. Outside the window: never respond, `iomem_ready` stays 0.
- Registers, by offset `iomem_addr[7:2]`:
  - 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN.
  - 0x04 PRESCALE: `[PRESCALE_W-1:0]`.
  - 0x08 RELOAD: 32 bit.
  - 0x0C COUNT: 32 bit; a write loads it.
  - 0x10 STATUS: bit0 EXPIRED, write-1-to-clear via `wstrb[0] & wdata[0]`.
- Other offsets in the window: read 0, writes ignored, still acknowledged.
- Writes honour byte strobes per byte lane. Unused bits read 0.
- Bus FSM:
  - IDLE: on `sel`, commit the write or capture read data, then go to ACK.
  - ACK: `iomem_ready`=1, `iomem_rdata` driven, unconditionally return to IDLE.
  - `sel` is never sampled in ACK, so a request is never accepted twice.
- Prescaler `pcnt` (PRESCALE_W bits):
  - While EN=1, counts 0..PRESCALE; `tick` fires when `pcnt==PRESCALE`, then `pcnt` returns to 0.
  - While EN=0, held at 0.
- On `tick`:
  - COUNT≠0: COUNT decrements.
  - COUNT==0: EXPIRED←1. If AUTO_RELOAD, COUNT←RELOAD; otherwise EN←0 (one-shot).
- Expiry period: (RELOAD+1)·(PRESCALE+1) cycles.
- Simultaneous events:
  - Bus write to COUNT in the tick cycle: the write wins and `pcnt`←0.
  - Write to PRESCALE, or a CTRL write that takes EN 0→1: `pcnt`←0.
  - EXPIRED set and W1C in the same cycle: set wins.
  - CTRL write in the one-shot expiry cycle: the written EN wins.
- Arithmetic: COUNT wraps never. Decrement occurs only from nonzero, so no underflow.

## Timing
- Reset values: all registers 0, `pcnt`=0, FSM IDLE, `iomem_ready`=0, `iomem_rdata`=0, `irq`=0.
- Reset mid-transaction: the transaction is dropped; `iomem_ready` is 0 the cycle after reset is sampled.
- Latency: `sel` sampled at edge N, `iomem_ready`=1 during cycle N+1 for exactly one cycle.
- Back-to-back accesses: minimum 2 cycles each.
- Read data is the register value at edge N. Write effects are visible from edge N onward.
- `irq` is combinational from registers and rises the cycle after the expiry tick edge.

## Structure
- Package `picosoc_timer_pkg`: register offsets, CTRL/STATUS bit positions, FSM state encoding (IDLE=0, ACK=1).
- Sub-module `picosoc_timer_prescaler`: inputs `clk`, `reset`, `en`, `clr`, `prescale`; output `tick`.
- Bus decode, register file and counter stay in the top module.

## Test plan
- Reset, then read every offset 0x00..0x14 → each returns 0 with `iomem_ready` exactly one cycle after `iomem_valid`; `irq`=0.
- Access 0x0400_0000 for 10 cycles → `iomem_ready` never asserts.
- PRESCALE=3, RELOAD=4, COUNT=4, CTRL=0x7 → EXPIRED and `irq` rise 20 cycles after the CTRL ack; they recur every 20 cycles. Write STATUS=1 → `irq` falls next cycle.
- One-shot: CTRL=0x1, PRESCALE=0, COUNT=2 → EXPIRED after 3 ticks; CTRL reads 0x0; COUNT stays 0.
- Byte strobes: RELOAD=0xFFFF_FFFF, then write 0x1234_5678 with `wstrb`=4'b0100 → RELOAD reads 0xFF34_FFFF.
- Collision: write COUNT=9 in the tick cycle with COUNT=1 → COUNT reads 9 and `pcnt` restarts. W1C of STATUS in an expiry cycle → EXPIRED stays 1.
